// File: rtl/array_sequencer.sv
// Control FSM for one systolic-array pass: fetch ARRAY_DIM weight rows, stream
// num_rows input rows, then write every activated output row back to SRAM.
module array_sequencer #(
  parameter int ARRAY_DIM = 8,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [ADDR_W-1:0] input_base,
  input  logic [ADDR_W-1:0] output_base,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [63:0]       sram_rdata,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [63:0]       sram_wdata,
  output logic              load,
  output logic              array_start,
  output logic [63:0]       inputs,
  input  logic              array_busy,
  input  logic              activations_valid,
  input  logic [63:0]       activations,
  output logic              design_busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] DIM    = CNT_W'(ARRAY_DIM);
  localparam logic [CNT_W-1:0] DIM_M1 = CNT_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    num_rows_q, num_rows_d;
  logic [ADDR_W-1:0]   weight_base_q, weight_base_d;
  logic [ADDR_W-1:0]   input_base_q, input_base_d;
  logic [ADDR_W-1:0]   output_base_q, output_base_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                load_q, load_d;
  logic                array_start_q, array_start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    num_rows_d    = num_rows_q;
    weight_base_d = weight_base_q;
    input_base_d  = input_base_q;
    output_base_d = output_base_q;
    rd_cnt_d      = rd_cnt_q;
    ld_cnt_d      = ld_cnt_q;
    out_cnt_d     = out_cnt_q;
    ren_d         = 1'b0;
    raddr_d       = raddr_q;
    wen_d         = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    load_d        = 1'b0;
    array_start_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    // Output capture runs alongside streaming so early results are not lost.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && activations_valid &&
        (out_cnt_q < num_rows_q)) begin
      wen_d     = 1'b1;
      waddr_d   = output_base_q + ADDR_W'(out_cnt_q);
      wdata_d   = activations;
      out_cnt_d = out_cnt_q + ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            num_rows_d    = num_rows;
            weight_base_d = weight_base;
            input_base_d  = input_base;
            output_base_d = output_base;
            ren_d         = 1'b1;
            raddr_d       = weight_base;
            rd_cnt_d      = ONE;
            ld_cnt_d      = '0;
            out_cnt_d     = '0;
            state_d       = S_LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        load_d = ren_q;
        if (rd_cnt_q < DIM) begin
          ren_d    = 1'b1;
          raddr_d  = weight_base_q + ADDR_W'(rd_cnt_q);
          rd_cnt_d = rd_cnt_q + ONE;
        end
        if (load_q) begin
          ld_cnt_d = ld_cnt_q + ONE;
          if (ld_cnt_q == DIM_M1) begin
            ld_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        array_start_d = ren_q;
        if ((rd_cnt_q < num_rows_q) && !array_busy) begin
          ren_d    = 1'b1;
          raddr_d  = input_base_q + ADDR_W'(rd_cnt_q);
          rd_cnt_d = rd_cnt_q + ONE;
        end
        // All reads issued and nothing in flight: this strobe is the last row.
        if (array_start_q && !ren_q && (rd_cnt_q == num_rows_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_d == num_rows_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rd_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d       = S_IDLE;
      ren_d         = 1'b0;
      wen_d         = 1'b0;
      load_d        = 1'b0;
      array_start_d = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      rd_cnt_d      = '0;
      ld_cnt_d      = '0;
      out_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      num_rows_q    <= '0;
      weight_base_q <= '0;
      input_base_q  <= '0;
      output_base_q <= '0;
      rd_cnt_q      <= '0;
      ld_cnt_q      <= '0;
      out_cnt_q     <= '0;
      ren_q         <= 1'b0;
      raddr_q       <= '0;
      wen_q         <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      load_q        <= 1'b0;
      array_start_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q       <= state_d;
      num_rows_q    <= num_rows_d;
      weight_base_q <= weight_base_d;
      input_base_q  <= input_base_d;
      output_base_q <= output_base_d;
      rd_cnt_q      <= rd_cnt_d;
      ld_cnt_q      <= ld_cnt_d;
      out_cnt_q     <= out_cnt_d;
      ren_q         <= ren_d;
      raddr_q       <= raddr_d;
      wen_q         <= wen_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      load_q        <= load_d;
      array_start_q <= array_start_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign sram_ren    = ren_q;
  assign sram_raddr  = raddr_q;
  assign sram_wen    = wen_q;
  assign sram_waddr  = waddr_q;
  assign sram_wdata  = wdata_q;
  assign load        = load_q;
  assign array_start = array_start_q;
  assign done        = done_q;
  assign err         = err_q;
  assign design_busy = (state_q != S_IDLE);
  // SRAM read data is already registered; gate it so the bus idles at zero.
  assign inputs      = (load_q || array_start_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_array_sequencer.sv
// Scoreboard bench for array_sequencer: a behavioural SRAM feeds the pass and
// load/row/write traffic is popped against queues filled as stimulus is driven.
module tb_array_sequencer;

  localparam int ARRAY_DIM = 8;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_rows = '0;
  logic [7:0]  weight_base = '0;
  logic [7:0]  input_base = '0;
  logic [7:0]  output_base = '0;
  logic        sram_ren;
  logic [7:0]  sram_raddr;
  logic [63:0] sram_rdata = '0;
  logic        sram_wen;
  logic [7:0]  sram_waddr;
  logic [63:0] sram_wdata;
  logic        load;
  logic        array_start;
  logic [63:0] inputs;
  logic        array_busy = 1'b0;
  logic        activations_valid = 1'b0;
  logic [63:0] activations = '0;
  logic        design_busy;
  logic        done;
  logic        err;

  array_sequencer #(.ARRAY_DIM(ARRAY_DIM), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .num_rows(num_rows), .weight_base(weight_base), .input_base(input_base),
    .output_base(output_base), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata), .sram_wen(sram_wen), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .load(load), .array_start(array_start),
    .inputs(inputs), .array_busy(array_busy),
    .activations_valid(activations_valid), .activations(activations),
    .design_busy(design_busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_ld = 0;
  int last_ld = 0;
  int ld_seen = 0;
  int as_seen = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic busy_prev = 1'b0;

  logic [63:0] exp_load[$];
  logic [63:0] exp_as[$];
  wr_t         exp_wr[$];

  function automatic logic [63:0] word(input logic [7:0] a);
    return {56'h5AC3_960F_E124_7B, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= array_busy;
    if (sram_ren) sram_rdata <= word(sram_raddr);
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (load) begin
          ld_seen++;
          if (ld_seen == 1) first_ld = cyc;
          last_ld = cyc;
          if (exp_load.size() == 0) check("load_extra", 64'(load), 64'd0);
          else check("load_data", inputs, exp_load.pop_front());
        end
        if (array_start) begin
          as_seen++;
          if (exp_as.size() == 0) check("row_extra", 64'(array_start), 64'd0);
          else check("row_data", inputs, exp_as.pop_front());
        end
        if (sram_wen) begin
          wr_seen++;
          if (exp_wr.size() == 0) check("write_extra", 64'(sram_wen), 64'd0);
          else begin
            e = exp_wr.pop_front();
            check("write_addr", 64'(sram_waddr), 64'(e.addr));
            check("write_data", sram_wdata, e.data);
          end
        end
        if (sram_ren) begin
          rd_seen++;
          check("ren_while_busy", 64'(busy_prev), 64'd0);
        end
        if (done) done_seen++;
        if (err) err_seen++;
      end
    end
  end

  task automatic run_pass(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                          input logic [7:0] n, input int stall, input int n_act, input bit dup);
    int budget;
    logic [63:0] d;
    wr_t e;
    ld_seen = 0; as_seen = 0; done_seen = 0; err_seen = 0;
    for (int i = 0; i < ARRAY_DIM; i++) exp_load.push_back(word(wb + 8'(i)));
    for (int i = 0; i < int'(n); i++) exp_as.push_back(word(ib + 8'(i)));
    weight_base = wb; input_base = ib; output_base = ob; num_rows = n;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(design_busy), 64'd1);
    if (dup) begin
      tick(); tick();
      num_rows = 8'd7; weight_base = 8'hA0; input_base = 8'hB0; output_base = 8'hC0;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (stall > 0) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!array_start && budget < 100);
      check("stall_wait", 64'(budget < 100), 64'd1);
      array_busy = 1'b1;
      repeat (stall) @(posedge clk);
      #1 array_busy = 1'b0;
    end
    budget = 0;
    while (as_seen < int'(n) && budget < 500) begin
      tick();
      budget++;
    end
    check("rows_wait", 64'(budget < 500), 64'd1);
    check("first_load_cycle", 64'(first_ld - start_cyc), 64'd2);
    check("last_load_cycle", 64'(last_ld - start_cyc), 64'd9);
    check("load_count", 64'(ld_seen), 64'd8);
    for (int k = 0; k < n_act; k++) begin
      d = {$urandom, $urandom};
      activations_valid = 1'b1;
      activations = d;
      if (k < int'(n)) begin
        e.addr = ob + 8'(k);
        e.data = d;
        exp_wr.push_back(e);
      end
      tick();
    end
    activations_valid = 1'b0;
    activations = '0;
    budget = 0;
    while (done_seen == 0 && budget < 100) begin
      tick();
      budget++;
    end
    tick(); tick();
    check("done_count", 64'(done_seen), 64'd1);
    check("err_count", 64'(err_seen), 64'd0);
    check("idle_after_done", 64'(design_busy), 64'd0);
    check("row_count", 64'(as_seen), 64'(n));
    check("loads_left", 64'(exp_load.size()), 64'd0);
    check("rows_left", 64'(exp_as.size()), 64'd0);
    check("writes_left", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int rd0, wr0;
    #3;
    check("rst_outputs", {57'd0, sram_ren, sram_wen, load, array_start, design_busy, done, err}, 64'd0);
    check("rst_addr", {48'd0, sram_raddr, sram_waddr}, 64'd0);
    check("rst_data", sram_wdata | inputs, 64'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Basic pass, then backpressure, then zero rows.
    run_pass(8'h00, 8'h10, 8'h40, 8'd4, 0, 4, 1'b0);
    run_pass(8'h08, 8'h20, 8'h50, 8'd3, 5, 3, 1'b0);

    rd0 = rd_seen; wr0 = wr_seen; err_seen = 0;
    num_rows = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("zero_err_pulse", 64'(err), 64'd1);
    check("zero_busy", 64'(design_busy), 64'd0);
    @(negedge clk);
    check("zero_err_one_cycle", 64'(err), 64'd0);
    repeat (4) tick();
    check("zero_no_reads", 64'(rd_seen - rd0), 64'd0);
    check("zero_no_writes", 64'(wr_seen - wr0), 64'd0);
    check("zero_err_count", 64'(err_seen), 64'd1);

    // Output wrap-around with extra valids after the last row is written.
    run_pass(8'h00, 8'h30, 8'hFE, 8'd3, 0, 5, 1'b0);
    // Second start during LOAD_W must be ignored.
    run_pass(8'h10, 8'h60, 8'h70, 8'd2, 0, 2, 1'b1);

    wr0 = wr_seen;
    repeat (3) begin
      activations_valid = 1'b1;
      activations = {$urandom, $urandom};
      tick();
    end
    activations_valid = 1'b0;
    tick();
    check("idle_stray_write", 64'(wr_seen - wr0), 64'd0);

    // Asynchronous reset in the middle of LOAD_W.
    for (int i = 0; i < ARRAY_DIM; i++) exp_load.push_back(word(8'h20 + 8'(i)));
    weight_base = 8'h20; input_base = 8'h28; output_base = 8'h30; num_rows = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 n_rst = 1'b0;
    #1;
    check("arst_strobes", {59'd0, sram_ren, sram_wen, load, array_start, design_busy}, 64'd0);
    check("arst_inputs", inputs, 64'd0);
    exp_load.delete();
    exp_as.delete();
    tick();
    n_rst = 1'b1;
    tick();
    check("arst_idle", 64'(design_busy), 64'd0);

    // Abort two cycles into STREAM: only the row already returned is shown.
    ld_seen = 0; as_seen = 0; done_seen = 0;
    for (int i = 0; i < ARRAY_DIM; i++) exp_load.push_back(word(8'h40 + 8'(i)));
    exp_as.push_back(word(8'h80));
    weight_base = 8'h40; input_base = 8'h80; output_base = 8'h90; num_rows = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(design_busy), 64'd0);
    check("abort_strobes", {60'd0, sram_ren, load, array_start, sram_wen}, 64'd0);
    repeat (5) tick();
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_rows", 64'(as_seen), 64'd1);
    check("abort_loads", 64'(ld_seen), 64'd8);
    check("abort_idle", 64'(design_busy), 64'd0);

    run_pass(8'h30, 8'h50, 8'h60, 8'd2, 0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
